imm_encoder: RTL

//  Inverse of the decode-side immediate sign-extender: packs a 32-bit immediate into the
//  I/S/B/U/J bit positions of an instruction template, and expands the LI pseudo-op

---
 rtl/imm_encoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Purpose:
//   Packs a 32-bit two's-complement immediate into the I/S/B/U/J immediate bit
//   positions of an instruction template. This is the inverse of the decode-side
//   sign-extender. It also expands the LI pseudo-op into a single ADDI, a single
//   LUI, or a LUI followed by an ADDI. It feeds instruction memory from the
//   program loader / self-test generator. The output has one registered stage.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid && ready. A producer
//   holding valid keeps its payload stable until the transfer. Here out_valid,
//   out_instr, out_last and out_err stay stable while out_valid && !out_ready.
//   in_ready is combinational; it never depends on in_valid.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous reset, active-low
//   in_valid   in   1   request valid
//   in_ready   out  1   request accepted when in_valid && in_ready
//   in_fmt     in   3   0=I 1=S 2=B 3=U 4=J 5=LI, 6/7 illegal
//   in_imm     in   32  immediate (byte offset for B/J)
//   in_base    in   32  template; immediate fields overwritten, LI uses rd=[11:7]
//   out_valid  out  1   instruction beat valid
//   out_ready  in   1   consumer accepts beat when out_valid && out_ready
//   out_instr  out  32  encoded instruction (NOP_INSTR when idle)
//   out_last   out  1   final beat of the request
//   out_err    out  1   immediate not representable in the format / illegal fmt
//   dbg_state  out  1   FSM state (0=IDLE, 1=EMIT2), for observation only
//
// Configuration:
//   IMM_ENC_RANGE_CHECK_EN - when defined, out_err also flags immediates that
//   the field truncation cannot represent. The encoding is the same either way.
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        EMIT2 = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;
    logic        out_err_q, out_err_d;
    logic [31:0] addi_q, addi_d;

    logic        accept;
    logic [31:0] enc_instr;
    logic        enc_last;
    logic        enc_err;
    logic        enc_two;
    logic [31:0] enc_addi;
    logic        range_err;

    // LI helpers
    logic [4:0]  li_rd;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic        li_small;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign li_rd    = in_base[11:7];
    assign li_lo    = in_imm[11:0];
    // (imm + 0x800) >> 12: the carry into bit 12 is exactly imm[11]. ADDI
    // sign-extends lo, so hi has to compensate when lo is negative.
    assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
    // The value fits a sign-extended 12-bit ADDI immediate.
    assign li_small = (&in_imm[31:11]) || !(|in_imm[31:11]);

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic i_fits, b_fits, j_fits;
    assign i_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign b_fits = !in_imm[0] && ((&in_imm[31:12]) || !(|in_imm[31:12]));
    assign j_fits = !in_imm[0] && ((&in_imm[31:20]) || !(|in_imm[31:20]));

    always_comb begin
        range_err = 1'b0;
        case (in_fmt)
            3'd0, 3'd1: range_err = !i_fits;
            3'd2:       range_err = !b_fits;
            3'd3:       range_err = |in_imm[11:0];
            3'd4:       range_err = !j_fits;
            default:    range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Combinational encoder: the first beat for the current request.
    always_comb begin
        enc_instr = in_base;
        enc_last  = 1'b1;
        enc_err   = 1'b0;
        enc_two   = 1'b0;
        enc_addi  = NOP_INSTR;
        case (in_fmt)
            3'd0: enc_instr = {in_imm[11:0], in_base[19:0]};
            3'd1: enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
            3'd2: enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12],
                               in_imm[4:1], in_imm[11], in_base[6:0]};
            3'd3: enc_instr = {in_imm[31:12], in_base[11:0]};
            3'd4: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11],
                               in_imm[19:12], in_base[11:0]};
            3'd5: begin
                if (li_small) begin
                    enc_instr = {li_lo, 5'd0, 3'b000, li_rd, 7'h13};
                end else if (li_lo == 12'd0) begin
                    enc_instr = {li_hi, li_rd, 7'h37};
                end else begin
                    enc_instr = {li_hi, li_rd, 7'h37};
                    enc_last  = 1'b0;
                    enc_two   = 1'b1;
                    enc_addi  = {li_lo, li_rd, 3'b000, li_rd, 7'h13};
                end
            end
            default: enc_err = 1'b1;
        endcase
        // LI never flags; range_err is already 0 for fmt 5.
        if (in_fmt <= 3'd4) begin
            enc_err = range_err;
        end
    end

    // Next-state logic for the FSM and the output register.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        addi_d      = addi_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_last_d  = enc_last;
            out_err_d   = enc_err;
            if (enc_two) begin
                state_d = EMIT2;
                addi_d  = enc_addi;
            end
        end else if (state_q == EMIT2) begin
            // The LUI beat is in the output register; swap in the ADDI once it is taken.
            if (out_ready) begin
                out_instr_d = addi_q;
                out_last_d  = 1'b1;
                out_err_d   = 1'b0;
                state_d     = IDLE;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            out_last_d  = 1'b0;
            out_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            addi_q      <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            addi_q      <= addi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;
    assign dbg_state = (state_q == EMIT2);

endmodule
